gray_counter_arbiter: RTL and testbench
=======================================

GRAY_COUNTER_ARBITER -- requirements
Module: gray_counter_arbiter

Interface
REQ-001 The block SHALL take parameter STEP_W, default 4: width of the step-count request fields.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have ports req0 and req1, input, 1 each: requester 0/1 asks to run the shared counter.
REQ-005 The block SHALL have ports dir0 and dir1, input, 1 each: requested direction (1 = up, 0 = down).
REQ-006 The block SHALL have ports steps0 and steps1, input, STEP_W each: number of Gray steps requested.
REQ-007 The block SHALL have port gnt, output, 2: one-hot grant (bit0 = requester 0, bit1 = requester 1).
REQ-008 The block SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-009 The block SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 The block SHALL have port Y, output, 3: the shared 3-bit Gray counter value, registered.

Function
REQ-011 The block SHALL implement the states IDLE, RUN and DONE.
REQ-012 IDLE SHALL sample req0/req1 on each edge; with any request pending, it SHALL grant exactly one requester and latch its dir and steps.
- Latched steps load into remaining counter rem; gnt bit set on the same edge.
REQ-013 When both requests are pending, the grant SHALL go to the requester not granted last (round-robin); after reset the priority SHALL favour requester 0.
REQ-014 On a grant with steps > 0, the state SHALL go to RUN; with steps = 0 it SHALL go directly to DONE, and Y SHALL be unchanged.
REQ-015 In RUN, each edge SHALL advance Y one Gray step in the latched direction and decrement rem; the edge on which rem = 1 SHALL move the state to DONE.
- Up sequence: 000,001,011,010,110,111,101,100, then wraps to 000.
- Down is the exact reverse; 000 down wraps to 100.
REQ-016 Exactly one bit of Y SHALL change per RUN edge, including at wrap-around.
REQ-017 In RUN, if the granted requester's req is low at an edge, that edge SHALL NOT move Y, and the state SHALL go to DONE (abort).
REQ-018 Requests from the non-granted requester during RUN/DONE SHALL be ignored; they are sampled only in IDLE.
REQ-019 Changes to dir/steps after the grant SHALL have no effect on the current run.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle; the next edge SHALL return to IDLE, clear gnt and record the last-granted requester.
REQ-021 gnt SHALL be held from the grant edge through the DONE cycle and SHALL be 00 in IDLE.
REQ-022 Y SHALL hold its value between runs; a new run SHALL start from the current Y, not from 000.
REQ-023 Minimum latency SHALL be: grant edge + steps RUN edges + 1 DONE cycle; back-to-back grants SHALL have at least one IDLE cycle between them.

Reset
REQ-024 reset = 0 SHALL immediately, without waiting for clk, force state = IDLE, Y = 000, gnt = 00, busy = 0, done = 0, rem = 0 and priority = requester 0.
REQ-025 Reset asserted mid-run SHALL abandon the run with no done pulse; after release, the block SHALL resume from IDLE.

Verification
REQ-026 The bench SHALL cover: reset, then req0 = 1, dir0 = 1, steps0 = 3 -> gnt = 01 on edge 1; Y = 001, 011, 010 on edges 2-4; done = 1 for one cycle; gnt = 00 after edge 5.
REQ-027 The bench SHALL cover: with Y = 000, req1 = 1, dir1 = 0, steps1 = 2 -> gnt = 10; Y = 100, then 101; done pulses once.
REQ-028 The bench SHALL cover: req0 and req1 both held high continuously, steps = 1 each -> grants alternate 01, 10, 01, with one IDLE cycle between runs.
REQ-029 The bench SHALL cover: steps0 = 0 -> gnt = 01 and done = 1 in the same cycle; Y unchanged; busy high for exactly 1 cycle.
REQ-030 The bench SHALL cover: steps0 = 8, with req0 dropped after 3 Y moves -> Y stops at 010 and done pulses the next cycle; steps0 = 8 uninterrupted -> Y returns to its start value.
REQ-031 The bench SHALL cover: reset pulsed low between clock edges during RUN -> Y = 000, gnt = 00, busy = 0 immediately, and no done pulse.

Source files
------------

// File: rtl/gray_counter_arbiter.sv
// rtl/gray_counter_arbiter.sv - two-requester round-robin arbiter driving a shared 3-bit Gray counter
`timescale 1ns/1ps
module gray_counter_arbiter #(
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              dir0,
  input  logic              dir1,
  input  logic [STEP_W-1:0] steps0,
  input  logic [STEP_W-1:0] steps1,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              done,
  output logic [2:0]        Y
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [2:0]          r_y;
  logic [1:0]          r_gnt;
  logic                r_busy;
  logic                r_done;
  logic                r_dir;
  logic [STEP_W-1:0]   r_rem;
  // r_prio = 1 means requester 1 wins a tie; cleared by reset so requester 0 wins first
  logic                r_prio;

  logic                w_any_req;
  logic                w_pick1;
  logic                w_sel_dir;
  logic [STEP_W-1:0]   w_sel_steps;
  logic                w_owner_req;
  logic [2:0]          w_y_next;

  // One Gray step: decode to binary, add or subtract one modulo 8, re-encode.
  // Re-encoding a modulo-8 binary count guarantees a single-bit change, wrap included.
  function automatic logic [2:0] gray_step(input logic [2:0] g, input logic up);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = g[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    b    = up ? (b + 3'd1) : (b - 3'd1);
    return b ^ {1'b0, b[2:1]};
  endfunction

  // Arbitration and next-value selection, all combinational from the current state
  always_comb begin
    w_any_req   = req0 | req1;
    w_pick1     = req1 & (~req0 | r_prio);
    w_sel_dir   = w_pick1 ? dir1 : dir0;
    w_sel_steps = w_pick1 ? steps1 : steps0;
    w_owner_req = r_gnt[0] ? req0 : req1;
    w_y_next    = gray_step(r_y, r_dir);
  end

  // Controller FSM with every output registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_y     <= 3'b000;
      r_gnt   <= 2'b00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dir   <= 1'b0;
      r_rem   <= '0;
      r_prio  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt  <= w_pick1 ? 2'b10 : 2'b01;
            r_dir  <= w_sel_dir;
            r_rem  <= w_sel_steps;
            r_busy <= 1'b1;
            if (w_sel_steps == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!w_owner_req) begin
            // owner withdrew: finish without moving Y
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_y   <= w_y_next;
            r_rem <= r_rem - STEP_W'(1);
            if (r_rem == STEP_W'(1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_gnt   <= 2'b00;
          r_prio  <= r_gnt[0];
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_gnt   <= 2'b00;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign busy = r_busy;
  assign done = r_done;
  assign Y    = r_y;

endmodule

// File: tb/tb_gray_counter_arbiter.sv
// tb/tb_gray_counter_arbiter.sv - directed scoreboard bench for gray_counter_arbiter
`timescale 1ns/1ps
module tb_gray_counter_arbiter;

  localparam int STEP_W = 4;

  logic              clk;
  logic              reset;
  logic              req0;
  logic              req1;
  logic              dir0;
  logic              dir1;
  logic [STEP_W-1:0] steps0;
  logic [STEP_W-1:0] steps1;
  logic [1:0]        gnt;
  logic              busy;
  logic              done;
  logic [2:0]        Y;

  typedef struct {
    logic [1:0] gnt;
    logic       busy;
    logic       done;
    logic [2:0] y;
  } exp_t;

  exp_t sb[$];

  int   n_assert;
  int   n_fail;
  logic [2:0] m_y;
  bit         m_prio;

  logic [2:0] gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  gray_counter_arbiter #(.STEP_W(STEP_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .req1   (req1),
    .dir0   (dir0),
    .dir1   (dir1),
    .steps0 (steps0),
    .steps1 (steps1),
    .gnt    (gnt),
    .busy   (busy),
    .done   (done),
    .Y      (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] next_gray(input logic [2:0] g, input logic up);
    int idx;
    idx = 0;
    for (int i = 0; i < 8; i++) if (gseq[i] == g) idx = i;
    return up ? gseq[(idx + 1) % 8] : gseq[(idx + 7) % 8];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] g, input logic b, input logic d, input logic [2:0] y);
    exp_t e;
    e.gnt  = g;
    e.busy = b;
    e.done = d;
    e.y    = y;
    sb.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s scoreboard empty observed=1 expected=0", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".gnt"},  {6'd0, gnt},  {6'd0, e.gnt});
      chk({tag, ".busy"}, {7'd0, busy}, {7'd0, e.busy});
      chk({tag, ".done"}, {7'd0, done}, {7'd0, e.done});
      chk({tag, ".y"},    {5'd0, Y},    {5'd0, e.y});
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    chk("rst.gnt",  {6'd0, gnt},  8'd0);
    chk("rst.busy", {7'd0, busy}, 8'd0);
    chk("rst.done", {7'd0, done}, 8'd0);
    chk("rst.y",    {5'd0, Y},    8'd0);
    reset = 1'b1;
    m_y = 3'b000;
    m_prio = 1'b0;
  endtask

  task automatic drop_req(input int who);
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic do_run(input int who, input logic d, input int steps, input int drop_after);
    logic [1:0] g;
    int moved;
    bit stop;
    g = (who == 0) ? 2'b01 : 2'b10;
    if (who == 0) begin req0 = 1'b1; dir0 = d; steps0 = STEP_W'(steps); end
    else          begin req1 = 1'b1; dir1 = d; steps1 = STEP_W'(steps); end
    if (steps == 0) begin
      push(g, 1'b1, 1'b1, m_y);
      tick("grant_zero");
    end else begin
      push(g, 1'b1, 1'b0, m_y);
      tick("grant");
      // fields changed after the grant must not disturb the run
      if (who == 0) begin dir0 = ~d; steps0 = 4'd1; end
      else          begin dir1 = ~d; steps1 = 4'd1; end
      moved = 0;
      stop = 1'b0;
      for (int k = 0; k < steps + 1; k++) begin
        if (!stop) begin
          if (drop_after >= 0 && moved == drop_after) begin
            drop_req(who);
            push(g, 1'b1, 1'b1, m_y);
            tick("abort");
            stop = 1'b1;
          end else begin
            m_y = next_gray(m_y, d);
            moved++;
            push(g, 1'b1, (moved == steps), m_y);
            tick("step");
            if (moved == steps) stop = 1'b1;
          end
        end
      end
    end
    drop_req(who);
    push(2'b00, 1'b0, 1'b0, m_y);
    tick("idle");
    m_prio = (who == 0);
  endtask

  initial begin
    logic [2:0] y_start;
    int who;
    n_assert = 0;
    n_fail = 0;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    dir0 = 1'b0; dir1 = 1'b0;
    steps0 = '0; steps1 = '0;
    m_y = 3'b000;
    m_prio = 1'b0;
    #2;

    apply_reset();
    do_run(0, 1'b1, 3, -1);
    chk("up3.final", {5'd0, Y}, 8'h02);

    apply_reset();
    do_run(1, 1'b0, 2, -1);
    chk("down2.final", {5'd0, Y}, 8'h05);

    // both requesters held: grants must alternate with one IDLE cycle between
    req0 = 1'b1; req1 = 1'b1;
    dir0 = 1'b1; dir1 = 1'b0;
    steps0 = 4'd1; steps1 = 4'd1;
    for (int r = 0; r < 3; r++) begin
      who = m_prio ? 1 : 0;
      push((who == 0) ? 2'b01 : 2'b10, 1'b1, 1'b0, m_y);
      tick("rr.grant");
      m_y = next_gray(m_y, (who == 0));
      push((who == 0) ? 2'b01 : 2'b10, 1'b1, 1'b1, m_y);
      tick("rr.step");
      push(2'b00, 1'b0, 1'b0, m_y);
      tick("rr.idle");
      m_prio = (who == 0);
    end
    req0 = 1'b0; req1 = 1'b0;

    y_start = m_y;
    do_run(0, 1'b1, 0, -1);
    chk("zero.y_held", {5'd0, Y}, {5'd0, y_start});

    apply_reset();
    do_run(0, 1'b1, 8, 3);
    chk("abort.final", {5'd0, Y}, 8'h02);
    do_run(0, 1'b1, 8, -1);
    chk("full8.final", {5'd0, Y}, 8'h02);

    // asynchronous reset between edges in the middle of a run
    req0 = 1'b1; dir0 = 1'b1; steps0 = 4'd5;
    push(2'b01, 1'b1, 1'b0, m_y);
    tick("mid.grant");
    m_y = next_gray(m_y, 1'b1);
    push(2'b01, 1'b1, 1'b0, m_y);
    tick("mid.step");
    #3;
    reset = 1'b0;
    #1;
    chk("async.y",    {5'd0, Y},    8'd0);
    chk("async.gnt",  {6'd0, gnt},  8'd0);
    chk("async.busy", {7'd0, busy}, 8'd0);
    chk("async.done", {7'd0, done}, 8'd0);
    @(posedge clk);
    #1;
    chk("async.hold_done", {7'd0, done}, 8'd0);
    chk("async.hold_busy", {7'd0, busy}, 8'd0);
    req0 = 1'b0;
    reset = 1'b1;
    sb.delete();
    m_y = 3'b000;
    m_prio = 1'b0;
    push(2'b00, 1'b0, 1'b0, m_y);
    tick("post_rst.idle");
    do_run(1, 1'b1, 2, -1);
    chk("resume.final", {5'd0, Y}, 8'h03);

    chk("sb.drained", 8'(sb.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
